// File: rtl/program_loader.sv
// Boot loader: frames a length/words/checksum byte stream into instruction ROM writes from address 0.
// Latency: one registered ROM write per word, issued the cycle after its low byte. byte_ready is driven from state and start only.
module program_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_data,
    output logic                  cpu_reset,
    output logic                  loading,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_RUN, S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            sum_q, sum_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]           rom_data_q, rom_data_d;

    logic        xfer;
    logic [15:0] n_w;
    logic        last_word;

    assign loading    = (state_q != S_RUN) && (state_q != S_ERROR);
    assign byte_ready = loading && !start;
    assign xfer       = byte_valid && byte_ready;
    assign cpu_reset  = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERROR);
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;

    assign n_w       = {len_hi_q, byte_data};
    // Index stops at N-1, so comparing idx+1 against N marks the final word.
    assign last_word = ((17'(idx_q) + 17'd1) == {1'b0, len_q});

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        hi_d       = hi_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        rom_we_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;

        if (start) begin
            state_d = S_LEN_HI;
            sum_d   = 8'd0;
            idx_d   = '0;
        end else if (xfer) begin
            if (state_q != S_CHECK) begin
                sum_d = sum_q + byte_data;
            end
            case (state_q)
                S_LEN_HI: begin
                    len_hi_d = byte_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = n_w;
                    if ({1'b0, n_w} > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else if (n_w == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = byte_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    rom_we_d   = 1'b1;
                    rom_addr_d = idx_q;
                    rom_data_d = {hi_q, byte_data};
                    if (last_word) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    state_d = (byte_data == sum_q) ? S_RUN : S_ERROR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LEN_HI;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            hi_q       <= 8'd0;
            sum_q      <= 8'd0;
            idx_q      <= '0;
            rom_we_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            rom_we_q   <= rom_we_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of frames with expected outcome, plus a write scoreboard.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        rom_we;
    logic [11:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_reset, loading, done, error;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0] b [0:7];
        int         n;
        int         gap;
        logic       exp_done;
        logic       exp_err;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(12), .DEPTH(4096)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .cpu_reset(cpu_reset), .loading(loading), .done(done), .error(error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected word.
    always @(negedge clk) begin
        if (rom_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(rom_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(rom_addr), 32'(w.addr));
                chk("wr_data", 32'(rom_data), 32'(w.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            chk("ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        logic [15:0] nw;
        pulse_start();
        exp_q.delete();
        nw = {v.b[0], v.b[1]};
        if (nw <= 16'd4096) begin
            for (int k = 0; k < int'(nw); k++) begin
                exp_q.push_back({12'(k), v.b[2+2*k], v.b[3+2*k]});
            end
        end
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[i], (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0);
        end
        chk("frame_done",      32'(done),      32'(v.exp_done));
        chk("frame_error",     32'(error),     32'(v.exp_err));
        chk("frame_cpu_reset", 32'(cpu_reset), 32'(!v.exp_done));
        chk("frame_loading",   32'(loading),   32'd0);
        chk("frame_writes_left", 32'(exp_q.size()), 32'd0);
        if (v.exp_err) begin
            repeat (3) @(negedge clk);
            chk("err_ready_low", 32'(byte_ready), 32'd0);
            chk("err_hold",      32'(error),      32'd1);
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{b:'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC0,8'h00}, n:7, gap:0, exp_done:1'b1, exp_err:1'b0};
        tbl[1] = '{b:'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC1,8'h00}, n:7, gap:0, exp_done:1'b0, exp_err:1'b1};
        tbl[2] = '{b:'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3, gap:0, exp_done:1'b1, exp_err:1'b0};
        tbl[3] = '{b:'{8'h10,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:2, gap:0, exp_done:1'b0, exp_err:1'b1};
        tbl[4] = '{b:'{8'h00,8'h01,8'hFF,8'hFF,8'hFF,8'h00,8'h00,8'h00}, n:5, gap:2, exp_done:1'b1, exp_err:1'b0};
        tbl[5] = '{b:'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hC0,8'h00}, n:7, gap:5, exp_done:1'b1, exp_err:1'b0};

        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_loading",   32'(loading),   32'd1);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_error",     32'(error),     32'd0);
        chk("rst_rom_we",    32'(rom_we),    32'd0);
        chk("rst_rom_addr",  32'(rom_addr),  32'd0);
        chk("rst_rom_data",  32'(rom_data),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i]);
        end

        // Asynchronous reset in the middle of a frame.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rom_we",    32'(rom_we),    32'd0);
        chk("arst_rom_addr",  32'(rom_addr),  32'd0);
        chk("arst_rom_data",  32'(rom_data),  32'd0);
        chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("arst_loading",   32'(loading),   32'd1);
        chk("arst_done",      32'(done),      32'd0);
        chk("arst_error",     32'(error),     32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_frame(tbl[0]);

        // Start in the same cycle as byte 0x34: the byte must be refused.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h34;
        start      = 1'b1;
        #1;
        chk("abort_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("abort_loading", 32'(loading), 32'd1);
        chk("abort_no_write", 32'(rom_we), 32'd0);
        // Restart is implied: the full frame must parse from LEN_HI.
        exp_q.delete();
        exp_q.push_back({12'd0, 16'h1234});
        exp_q.push_back({12'd1, 16'hABCD});
        for (int i = 0; i < 7; i++) begin
            send_byte(tbl[0].b[i], 0);
        end
        chk("abort_done",      32'(done),         32'd1);
        chk("abort_cpu_reset", 32'(cpu_reset),    32'd0);
        chk("abort_writes",    32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time controller for the instruction ROM of the Hack computer.
- Receives a byte stream over a valid/ready handshake, frames it as length, program words and checksum, and writes the words into instruction memory from address 0.
- Holds the CPU in reset while loading and releases it only after a good checksum.
- A `start` pulse re-enters loading so a new program can be streamed without a full system reset.

Parameters:
- ADDR_WIDTH, 12, instruction memory address width.
- DEPTH, 4096, maximum program length in words; must not exceed 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to (re)load a program.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- rom_we  output  1  instruction memory write strobe.
- rom_addr  output  ADDR_WIDTH  write address.
- rom_data  output  16  write data.
- cpu_reset  output  1  active-high reset to the CPU.
- loading  output  1  high in any load state.
- done  output  1  last load succeeded; CPU running.
- error  output  1  last load failed.

Behaviour:
- Stream format (big-endian):
  - LEN_HI, LEN_LO give N = word count.
  - Then N words, each sent as high byte then low byte.
  - Then one CHK byte = mod-256 sum of every preceding byte of the frame, including the length bytes.
- Transfer occurs on a posedge where byte_valid && byte_ready.
  - byte_ready = (state is LEN_HI, LEN_LO, DATA_HI, DATA_LO or CHECK) && !start. It is combinational from state and start only, never from byte_valid.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR.
  - LEN_HI: on transfer, latch the high length byte and go to LEN_LO.
  - LEN_LO: on transfer, form N.
    - N > DEPTH: go to ERROR.
    - N == 0: go to CHECK.
    - Otherwise: go to DATA_HI.
  - DATA_HI: on transfer, latch the byte and go to DATA_LO.
  - DATA_LO: on transfer, register rom_data = {hi, byte} and rom_addr = word index, pulse rom_we for exactly the next cycle, and increment the index. When index+1 == N, go to CHECK; otherwise go to DATA_HI.
  - CHECK: on transfer, byte == running sum goes to RUN; otherwise go to ERROR.
  - RUN and ERROR: hold until start, which goes to LEN_HI and clears the sum, index, done and error.
- Running sum: 8-bit, wraps mod 256, updated on every accepted byte before CHECK.
- Outputs:
  - cpu_reset = 1 in every state except RUN. It deasserts on the first cycle in RUN, by which point the last rom_we has already completed.
  - loading = 1 in LEN_HI..CHECK.
  - done = 1 only in RUN; error = 1 only in ERROR.
  - rom_we is 0 except for the one-cycle pulses. rom_addr and rom_data hold their last value between writes.
- Reset (async, any state, including mid-word): state goes to LEN_HI, sum = 0, index = 0, rom_we = 0, rom_addr = 0, rom_data = 0, cpu_reset = 1, loading = 1, done = 0, error = 0. ROM contents are not cleared; the partial program stays but the CPU remains held.
- start while loading aborts and restarts at LEN_HI. A byte presented in that same cycle is not accepted. Any rom_we pulse already registered still completes.
- Words beyond N are never written. The index never exceeds N-1, so there is no address wrap.
- Stalls (byte_valid low) of any length are allowed in any load state without a timeout.

Test Plan:
- Nominal load: after reset release, stream 00 02 12 34 AB CD C0 → writes addr0=0x1234, addr1=0xABCD, one rom_we pulse each; then done=1, cpu_reset=0 the cycle after the C0 byte is accepted.
- Bad checksum: same frame with CHK=C1 → both words written, then error=1, done=0, cpu_reset stays 1. A following start plus the correct frame → done=1.
- Boundaries:
  - Empty program 00 00 00 → no rom_we, done=1.
  - Length 10 01 with DEPTH=4096 → error=1 right after the second byte; byte_ready=0 thereafter.
- Backpressure: insert 0-5 idle cycles between bytes of the nominal frame, with randomized byte_valid → identical writes and result; no byte is accepted twice.
- Reset and abort:
  - Assert reset after 00 02 12 → all outputs return to their reset values asynchronously.
  - Re-sending the full nominal frame then succeeds.
  - Separately, pulse start in the same cycle as byte 0x34 is presented → that byte is not accepted and loading restarts at LEN_HI.
